regfile_write_arbiter: RTL and testbench

- Shares the register file's single write port (regwrite/write_reg/write_data) between two writeback requesters.
  - Requester 0: ALU result path.
  - Requester 1: load/memory return path.
- Each requester has a one-entry holding slot. Arbitration is round-robin, and the write port is driven from registered outputs.
- Exports a per-register pending-write mask so the hazard logic can stall dependent reads.

---
 rtl/regfile_pkg.sv | 11 +
 rtl/wr_hold_slot.sv | 27 ++
 rtl/regfile_write_arbiter.sv | 81 ++++++++
 tb/tb_regfile_write_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, FSM states and busy-mask decode for the regfile write arbiter
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef enum logic {CLEAR, RUN} state_t;
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [ADDR_W-1:0] r);
    reg_onehot = '0;
    reg_onehot[r] = r != '0;
  endfunction
endpackage

// File: rtl/wr_hold_slot.sv
// wr_hold_slot: one-entry writeback buffer; a load on the grant edge refills instead of emptying
module wr_hold_slot
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  output logic              full,
  output logic [ADDR_W-1:0] slot_reg,
  output logic [DATA_W-1:0] slot_data
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      full <= 1'b0;
      slot_reg <= '0;
      slot_data <= '0;
    end else begin
      full <= load | (full & ~clr);
      if (load) begin
        slot_reg <= in_reg;
        slot_data <= in_data;
      end
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the regfile write port between ALU and load writeback.
// REGFILE_CLEAR_EN adds a CLEAR state that zeroes registers 1..NUM_REGS-1 after every reset.
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [ADDR_W-1:0]   req0_reg,
  input  logic [DATA_W-1:0]   req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [ADDR_W-1:0]   req1_reg,
  input  logic [DATA_W-1:0]   req1_data,
  output logic                regwrite,
  output logic [ADDR_W-1:0]   write_reg,
  output logic [DATA_W-1:0]   write_data,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                init_done
);
`ifdef REGFILE_CLEAR_EN
  localparam state_t ST_RST = CLEAR;
`else
  localparam state_t ST_RST = RUN;
`endif
  state_t state, state_nx;
  logic [ADDR_W-1:0] idx, r0, r1, gr;
  logic [DATA_W-1:0] d0, d1, gd;
  logic f0, f1, g0, g1, ld0, ld1, ptr, old1, run, same;
  wr_hold_slot u_slot0 (
    .clk(clk), .rst(rst), .load(ld0), .clr(g0), .in_reg(req0_reg), .in_data(req0_data),
    .full(f0), .slot_reg(r0), .slot_data(d0)
  );
  wr_hold_slot u_slot1 (
    .clk(clk), .rst(rst), .load(ld1), .clr(g1), .in_reg(req1_reg), .in_data(req1_data),
    .full(f1), .slot_reg(r1), .slot_data(d1)
  );
  // old1: slot 1 holds the older entry; only consulted when both slots target the same register
  always_comb begin
    run = state == RUN;
    same = f0 & f1 & (r0 == r1) & (r0 != '0);
    g1 = f1 & (~f0 | (same ? old1 : ptr));
    g0 = f0 & ~g1;
    gr = g1 ? r1 : r0;
    gd = g1 ? d1 : d0;
    req0_ready = run & (~f0 | g0);
    req1_ready = run & (~f1 | g1);
    ld0 = req0_valid & req0_ready;
    ld1 = req1_valid & req1_ready;
    init_done = run;
    busy_mask = (f0 ? reg_onehot(r0) : '0) | (f1 ? reg_onehot(r1) : '0) |
                (regwrite ? reg_onehot(write_reg) : '0);
    state_nx = (state == CLEAR && idx == ADDR_W'(NUM_REGS - 1)) ? RUN : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= ST_RST;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      regwrite <= 1'b0;
      write_reg <= '0;
      write_data <= '0;
      idx <= ADDR_W'(1);
      ptr <= 1'b0;
      old1 <= 1'b0;
    end else begin
      if (!run) begin
        regwrite <= 1'b1;
        write_reg <= idx;
        write_data <= '0;
        idx <= idx + 1'b1;
      end else if (g0 | g1) begin
        regwrite <= gr != '0;
        write_reg <= gr;
        write_data <= gd;
      end else regwrite <= 1'b0;
      if (f0 & f1) ptr <= g0;
      if (ld0 | ld1) old1 <= ld0 & ~ld1;
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and random writeback traffic against an age-stamped reference model
module tb_regfile_write_arbiter;
  import regfile_pkg::*;
  logic clk = 0, rst = 1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [ADDR_W-1:0] req0_reg = 0, req1_reg = 0, write_reg;
  logic [DATA_W-1:0] req0_data = 0, req1_data = 0, write_data;
  logic regwrite, init_done;
  logic [NUM_REGS-1:0] busy_mask;
  always #5 clk = ~clk;
  regfile_write_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_reg(req0_reg), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_reg(req1_reg), .req1_data(req1_data),
    .regwrite(regwrite), .write_reg(write_reg), .write_data(write_data),
    .busy_mask(busy_mask), .init_done(init_done)
  );
`ifdef REGFILE_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif
  int n_chk = 0, n_pass = 0;
  bit m_run, m_v[2], m_rw;
  int m_idx, m_seq, m_ptr, m_age[2];
  logic [ADDR_W-1:0] m_r[2], m_wreg;
  logic [DATA_W-1:0] m_d[2], m_wdata;
  logic [DATA_W-1:0] m_rf[NUM_REGS], dut_rf[NUM_REGS];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic int m_grant();
    if (m_v[0] && m_v[1]) begin
      if (m_r[0] == m_r[1] && m_r[0] != 0) return (m_age[0] < m_age[1]) ? 0 : 1;
      return m_ptr;
    end
    if (m_v[0]) return 0;
    if (m_v[1]) return 1;
    return -1;
  endfunction
  function automatic bit m_ready(input int k);
    return m_run && (!m_v[k] || m_grant() == k);
  endfunction
  function automatic logic [NUM_REGS-1:0] m_busy();
    logic [NUM_REGS-1:0] b = '0;
    for (int k = 0; k < 2; k++) if (m_v[k]) b[m_r[k]] = 1'b1;
    if (m_rw) b[m_wreg] = 1'b1;
    b[0] = 1'b0;
    return b;
  endfunction
  task automatic m_reset();
    m_run = !CLR_EN;
    m_idx = 1;
    m_v[0] = 0;
    m_v[1] = 0;
    m_ptr = 0;
    m_seq = 0;
    m_rw = 0;
    m_wreg = 0;
    m_wdata = 0;
  endtask
  task automatic cycle(input bit v0, input logic [ADDR_W-1:0] r0, input logic [DATA_W-1:0] d0,
                       input bit v1, input logic [ADDR_W-1:0] r1, input logic [DATA_W-1:0] d1);
    int g;
    bit rd[2], vi[2];
    logic [ADDR_W-1:0] ri[2];
    logic [DATA_W-1:0] di[2];
    chk("regwrite", regwrite, m_rw);
    if (m_rw) begin
      chk("write_reg", write_reg, m_wreg);
      chk("write_data", write_data, m_wdata);
    end
    if (regwrite) dut_rf[write_reg] = write_data;
    chk("ready0", req0_ready, m_ready(0));
    chk("ready1", req1_ready, m_ready(1));
    chk("busy_mask", busy_mask, m_busy());
    chk("init_done", init_done, m_run);
    req0_valid = v0; req0_reg = r0; req0_data = d0;
    req1_valid = v1; req1_reg = r1; req1_data = d1;
    vi[0] = v0; ri[0] = r0; di[0] = d0;
    vi[1] = v1; ri[1] = r1; di[1] = d1;
    g = m_grant();
    rd[0] = m_ready(0);
    rd[1] = m_ready(1);
    if (!m_run) begin
      m_rw = 1;
      m_wreg = ADDR_W'(m_idx);
      m_wdata = 0;
      if (m_idx == NUM_REGS - 1) m_run = 1;
      m_idx++;
    end else if (g >= 0) begin
      if (m_v[0] && m_v[1]) m_ptr = 1 - g;
      m_rw = m_r[g] != 0;
      m_wreg = m_r[g];
      m_wdata = m_d[g];
      m_v[g] = 0;
    end else m_rw = 0;
    if (m_rw) m_rf[m_wreg] = m_wdata;
    for (int k = 0; k < 2; k++)
      if (vi[k] && rd[k]) begin
        m_v[k] = 1;
        m_r[k] = ri[k];
        m_d[k] = di[k];
        m_age[k] = m_seq++;
      end
    @(negedge clk);
  endtask
  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    rst = 1;
    req0_valid = 0;
    req1_valid = 0;
    #1;
    chk("rst_regwrite", regwrite, 0);
    chk("rst_busy", busy_mask, 0);
    m_reset();
    @(negedge clk);
    rst = 0;
  endtask
  initial begin
    for (int i = 0; i < NUM_REGS; i++) begin
      m_rf[i] = 0;
      dut_rf[i] = 0;
    end
    m_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    repeat (40) idle();
    cycle(1, 5, 32'hDEADBEEF, 0, 0, 0);
    repeat (3) idle();
    repeat (8) cycle(1, 3, 32'h11, 1, 4, 32'h22);
    repeat (3) idle();
    cycle(1, 7, 32'hA, 1, 7, 32'hB);
    repeat (4) idle();
    chk("rf7_final", dut_rf[7], 32'hB);
    cycle(0, 0, 0, 1, 0, 32'hFFFF);
    repeat (3) idle();
    repeat (4) cycle(1, 3, 32'h11, 1, 4, 32'h22);
    do_reset();
    repeat (40) idle();
    repeat (400)
      cycle(1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), $urandom);
    repeat (5) idle();
    for (int i = 0; i < NUM_REGS; i++) chk($sformatf("rf[%0d]", i), dut_rf[i], m_rf[i]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
